spi_joystick_slave: RTL and testbench

//  SPI mode-0 responder emulating the joystick peripheral: answers 40-bit (5-byte) frames

---
 rtl/spi_joystick_slave.sv | 173 +++++++++++++++++
 tb/tb_spi_joystick_slave.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_joystick_slave.sv
// SPI mode-0 responder that stands in for the joystick peripheral.
// Each 40-bit frame returns a position/button snapshot and captures the
// master's command byte. All SPI pins are oversampled in the clk50M domain,
// and no logic is clocked by sck.
//
// Handshake: a frame opens on a synchronized cs falling edge and closes on a
// synchronized cs rising edge. At close, exactly one of frame_done or
// frame_err pulses for one clk50M cycle. rx_bytes and led change only in the
// cycle that frame_done is high.
module spi_joystick_slave #(
    parameter int FRAME_BITS  = 40,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk50M,
    input  logic        rst_n,
    input  logic        cs,
    input  logic        sck,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    input  logic [9:0]  x_pos,
    input  logic [9:0]  y_pos,
    input  logic [2:0]  buttons,
    output logic [39:0] rx_bytes,
    output logic [1:0]  led,
    output logic        frame_done,
    output logic        frame_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   cs_d;
    logic                   sck_d;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;
    logic [39:0]      tx_shift;
    logic [39:0]      rx_shift;
    logic             done_err;

    logic        cs_s;
    logic        sck_s;
    logic        mosi_s;
    logic        cs_fall;
    logic        cs_rise;
    logic        sck_rise;
    logic        sck_fall;
    logic [39:0] tx_frame;

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_d & ~cs_s;
    assign cs_rise  = ~cs_d & cs_s;
    assign sck_rise = ~sck_d & sck_s;
    assign sck_fall = sck_d & ~sck_s;

    // Snapshot layout: little-endian 16-bit X, then Y, then buttons.
    assign tx_frame = {x_pos[7:0], 6'b0, x_pos[9:8],
                       y_pos[7:0], 6'b0, y_pos[9:8],
                       5'b0, buttons};

    assign state_dbg = state;

    // Synchronize the SPI pins and keep one extra flop for edge detection.
    // cs resets low so that a cs held low through reset release does not
    // look like a falling edge.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync   <= '0;
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_d      <= 1'b0;
            sck_d     <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_d      <= cs_s;
            sck_d     <= sck_s;
        end
    end

    // Frame FSM. A cs edge takes priority over an sck edge seen in the same cycle.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            done_err   <= 1'b0;
            miso       <= 1'b0;
            miso_oe    <= 1'b0;
            rx_bytes   <= '0;
            led        <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= SHIFT;
                        tx_shift <= tx_frame;
                        bit_cnt  <= '0;
                        done_err <= 1'b0;
                        miso     <= tx_frame[39];
                        miso_oe  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        miso      <= 1'b0;
                        miso_oe   <= 1'b0;
                    end else if (sck_rise) begin
                        rx_shift <= {rx_shift[38:0], mosi_s};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_CNT) begin
                            state <= DONE;
                        end
                    end else if (sck_fall && bit_cnt < FULL_CNT) begin
                        tx_shift <= {tx_shift[38:0], 1'b0};
                        miso     <= tx_shift[38];
                    end
                end
                DONE: begin
                    if (cs_rise) begin
                        if (done_err) begin
                            frame_err <= 1'b1;
                        end else begin
                            frame_done <= 1'b1;
                            rx_bytes   <= rx_shift;
                            if (rx_shift[39:34] == 6'b100000) begin
                                led <= rx_shift[33:32];
                            end
                        end
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        done_err <= 1'b0;
                        miso     <= 1'b0;
                        miso_oe  <= 1'b0;
                    end else if (sck_rise) begin
                        done_err <= 1'b1;
                    end else if (sck_fall) begin
                        miso <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    miso    <= 1'b0;
                    miso_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_joystick_slave.sv
// Bench for spi_joystick_slave: a randomized SPI master drives frames.
// The expected frame outcome (done/err, rx_bytes, led) and the expected
// miso bit stream are queued when each frame starts. Two monitors pop and
// compare when the DUT pulses frame_done/frame_err and when cs closes.
module tb_spi_joystick_slave;

    logic        clk50M = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b1;
    logic        sck = 1'b0;
    logic        mosi = 1'b0;
    logic        miso;
    logic        miso_oe;
    logic [9:0]  x_pos = '0;
    logic [9:0]  y_pos = '0;
    logic [2:0]  buttons = '0;
    logic [39:0] rx_bytes;
    logic [1:0]  led;
    logic        frame_done;
    logic        frame_err;
    logic [1:0]  state_dbg;

    int n_pass = 0;
    int n_fail = 0;

    // Event entry: {is_err, led, rx_bytes}
    logic [42:0] exp_q[$];
    // Miso entry: {bit count, 41 expected bits MSB first}
    logic [46:0] exp_miso_q[$];

    logic [39:0] model_rx = '0;
    logic [1:0]  model_led = '0;

    spi_joystick_slave #(.FRAME_BITS(40), .SYNC_STAGES(2)) dut (
        .clk50M     (clk50M),
        .rst_n      (rst_n),
        .cs         (cs),
        .sck        (sck),
        .mosi       (mosi),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .buttons    (buttons),
        .rx_bytes   (rx_bytes),
        .led        (led),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .state_dbg  (state_dbg)
    );

    // Clock: 50 MHz
    always #10 clk50M = ~clk50M;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk50M);
    endtask

    // Reference snapshot: five bytes, little-endian X, little-endian Y, buttons.
    function automatic logic [39:0] ref_frame(input logic [9:0] x, input logic [9:0] y,
                                              input logic [2:0] b);
        logic [15:0] xw, yw;
        logic [7:0]  bw;
        xw = 16'(x);
        yw = 16'(y);
        bw = 8'(b);
        return {xw[7:0], xw[15:8], yw[7:0], yw[15:8], bw};
    endfunction

    // SPI master. nbits rising edges are sent; bits past 40 are zero.
    // If rst_at is nonzero, reset is pulsed after that many rising edges and
    // the frame is abandoned.
    task automatic spi_frame(input logic [39:0] data, input int nbits, input int half,
                             input int rst_at, input bit chg);
        logic [39:0] tx;
        int nb;
        tx = ref_frame(x_pos, y_pos, buttons);
        nb = (rst_at != 0) ? rst_at : nbits;
        exp_miso_q.push_back({6'(nb), tx, 1'b0});
        if (rst_at == 0) begin
            if (nbits == 40) begin
                model_rx = data;
                if (data[39:34] == 6'b100000) model_led = data[33:32];
                exp_q.push_back({1'b0, model_led, model_rx});
            end else begin
                exp_q.push_back({1'b1, model_led, model_rx});
            end
        end
        @(negedge clk50M);
        cs = 1'b0;
        mosi = data[39];
        for (int i = 0; i < nbits; i++) begin
            wait_clks(half);
            sck = 1'b1;
            if (rst_at != 0 && i + 1 == rst_at) begin
                wait_clks(1);
                rst_n = 1'b0;
                wait_clks(3);
                chk("rst_rx_bytes", 64'(rx_bytes), 64'h0);
                chk("rst_led", 64'(led), 64'h0);
                chk("rst_miso", 64'({miso, miso_oe}), 64'h0);
                chk("rst_pulses", 64'({frame_done, frame_err}), 64'h0);
                rst_n = 1'b1;
                model_rx = '0;
                model_led = '0;
                wait_clks(half);
                sck = 1'b0;
                break;
            end
            if (chg && i == 10) begin
                x_pos = 10'($urandom);
                y_pos = 10'($urandom);
                buttons = 3'($urandom);
            end
            wait_clks(half);
            sck = 1'b0;
            mosi = (i + 1 < 40) ? data[38 - i] : 1'b0;
        end
        wait_clks(half);
        cs = 1'b1;
        mosi = 1'b0;
        wait_clks(6);
        chk("idle_miso_oe", 64'(miso_oe), 64'h0);
        chk("idle_miso", 64'(miso), 64'h0);
        wait_clks($urandom_range(2, 6));
    endtask

    // Frame outcome monitor
    initial begin
        logic [42:0] e;
        forever begin
            @(negedge clk50M);
            if (rst_n && (frame_done || frame_err)) begin
                chk("done_err_exclusive", 64'(frame_done & frame_err), 64'h0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 64'({frame_done, frame_err}), 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_kind_err", 64'(frame_err), 64'(e[42]));
                    chk("rx_bytes", 64'(rx_bytes), 64'(e[39:0]));
                    chk("led", 64'(led), 64'(e[41:40]));
                end
            end
        end
    end

    // Miso monitor: captures miso on each master sck rise while cs is low.
    initial begin
        logic [46:0] e;
        logic [40:0] cap;
        logic [40:0] expv;
        int cnt;
        int n;
        forever begin
            @(negedge cs);
            cap = '0;
            cnt = 0;
            forever begin
                @(posedge sck or posedge cs);
                if (cs) break;
                if (cnt == 0) chk("miso_oe_active", 64'(miso_oe), 64'h1);
                cap = {cap[39:0], miso};
                cnt++;
            end
            if (exp_miso_q.size() == 0) begin
                chk("unexpected_miso_frame", 64'(cnt), 64'h0);
            end else begin
                e = exp_miso_q.pop_front();
                n = int'(e[46:41]);
                expv = e[40:0] >> (41 - n);
                chk("miso_count", 64'(cnt), 64'(n));
                chk("miso_bits", 64'(cap), 64'(expv));
            end
        end
    end

    initial begin
        logic [39:0] d;
        int waited;

        // Reset state
        wait_clks(4);
        chk("reset_rx_bytes", 64'(rx_bytes), 64'h0);
        chk("reset_led", 64'(led), 64'h0);
        chk("reset_miso", 64'({miso, miso_oe}), 64'h0);
        chk("reset_pulses", 64'({frame_done, frame_err}), 64'h0);
        chk("reset_state", 64'(state_dbg), 64'h0);
        rst_n = 1'b1;
        wait_clks(5);

        // Directed frame with a valid command
        x_pos = 10'h2A5;
        y_pos = 10'h13C;
        buttons = 3'b101;
        spi_frame(40'h8300000000, 40, 4, 0, 1'b0);
        chk("t1_led", 64'(led), 64'h3);
        chk("t1_rx_bytes", 64'(rx_bytes), 64'h8300000000);

        // Inputs change mid-frame; the next frame reports the new values.
        spi_frame({8'h80 | 8'($urandom_range(0, 3)), 32'($urandom)}, 40, 4, 0, 1'b1);
        spi_frame({8'($urandom), 32'($urandom)}, 40, 5, 0, 1'b0);

        // Early cs release, then a good frame
        spi_frame({8'h82, 32'($urandom)}, 17, 4, 0, 1'b0);
        spi_frame({8'($urandom), 32'($urandom)}, 40, 4, 0, 1'b0);

        // Invalid command: led must hold.
        spi_frame(40'h4100000000, 40, 4, 0, 1'b0);
        chk("t4_rx_bytes", 64'(rx_bytes), 64'h4100000000);

        // 41 sck pulses
        spi_frame({8'h81, 32'($urandom)}, 41, 4, 0, 1'b0);

        // Reset at bit 20 at sck = clk/8 and at 1 MHz
        for (int k = 0; k < 2; k++) begin
            x_pos = 10'($urandom);
            y_pos = 10'($urandom);
            buttons = 3'($urandom);
            spi_frame({8'h83, 32'($urandom)}, 40, (k == 0) ? 4 : 25, 20, 1'b0);
            spi_frame({8'h80 | 8'($urandom_range(0, 3)), 32'($urandom)}, 40,
                      (k == 0) ? 4 : 25, 0, 1'b0);
        end

        // Randomized frames
        for (int k = 0; k < 10; k++) begin
            x_pos = 10'($urandom);
            y_pos = 10'($urandom);
            buttons = 3'($urandom);
            d = {8'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 1) d[39:34] = 6'b100000;
            case ($urandom_range(0, 4))
                0:       spi_frame(d, $urandom_range(1, 39), $urandom_range(4, 6), 0, 1'b0);
                1:       spi_frame(d, 41, 4, 0, 1'b0);
                default: spi_frame(d, 40, $urandom_range(4, 7), 0, 1'($urandom));
            endcase
        end

        waited = 0;
        while ((exp_q.size() != 0 || exp_miso_q.size() != 0) && waited < 200) begin
            wait_clks(1);
            waited++;
        end
        chk("events_drained", 64'(exp_q.size()), 64'h0);
        chk("miso_frames_drained", 64'(exp_miso_q.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
